// File: rtl/sigma_tile_pkg.sv
// Shared types and default constants for the sigma_tile memory fabric.
// Optional build macro MEM_DEC_1M2S_ERR_RESP_EN adds the decoder error-response state.
package sigma_tile_pkg;

  // Decoder state: idle, or waiting for the read response of one slave
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRdS0  = 2'd1,
`ifdef MEM_DEC_1M2S_ERR_RESP_EN
    StRdS1  = 2'd2,
    StRdErr = 2'd3
`else
    StRdS1  = 2'd2
`endif
  } dec_state_t;

  // Default address windows
  localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] S0_MASK_DEF = 32'hFFFF_0000;
  localparam logic [31:0] S1_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] S1_MASK_DEF = 32'hF000_0000;

  // Read data returned for unmapped reads when the error response is built in
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_dec_1m2s_addr_match.sv
// Combinational address window match: hit when (addr & mask) == base.
module mem_addr_match (
  input  logic [31:0] addr_i,
  input  logic [31:0] base_i,
  input  logic [31:0] mask_i,
  output logic        hit_o
);

  assign hit_o = ((addr_i & mask_i) == base_i);

endmodule

// File: rtl/mem_dec_1m2s.sv
// One-master / two-slave MemSplit32 address decoder with split-phase read steering.
// Build macro MEM_DEC_1M2S_ERR_RESP_EN: unmapped accesses are answered locally
// (write dropped, read returns ERR_RDATA); otherwise they fall through to slave 1.
module mem_dec_1m2s
  import sigma_tile_pkg::*;
#(
  parameter logic [31:0] S0_BASE   = S0_BASE_DEF,
  parameter logic [31:0] S0_MASK   = S0_MASK_DEF,
  parameter logic [31:0] S1_BASE   = S1_BASE_DEF,
  parameter logic [31:0] S1_MASK   = S1_MASK_DEF,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Upstream port (from arbiter)
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [3:0]  m_be,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic        m_resp,
  output logic [31:0] m_rdata,
  // Slave 0 port
  output logic        s0_req,
  output logic        s0_we,
  output logic [31:0] s0_addr,
  output logic [3:0]  s0_be,
  output logic [31:0] s0_wdata,
  input  logic        s0_ack,
  input  logic        s0_resp,
  input  logic [31:0] s0_rdata,
  // Slave 1 port
  output logic        s1_req,
  output logic        s1_we,
  output logic [31:0] s1_addr,
  output logic [3:0]  s1_be,
  output logic [31:0] s1_wdata,
  input  logic        s1_ack,
  input  logic        s1_resp,
  input  logic [31:0] s1_rdata
);

  dec_state_t state_q, state_d;
  logic       hit_s0, sel_s0, sel_s1;

  mem_addr_match u_match_s0 (
    .addr_i (m_addr),
    .base_i (S0_BASE),
    .mask_i (S0_MASK),
    .hit_o  (hit_s0)
  );

`ifdef MEM_DEC_1M2S_ERR_RESP_EN
  logic hit_s1, unmapped;

  mem_addr_match u_match_s1 (
    .addr_i (m_addr),
    .base_i (S1_BASE),
    .mask_i (S1_MASK),
    .hit_o  (hit_s1)
  );

  // S0 wins on overlap; anything matching neither window is answered here
  assign sel_s0   = m_req & hit_s0;
  assign sel_s1   = m_req & ~hit_s0 & hit_s1;
  assign unmapped = m_req & ~hit_s0 & ~hit_s1;
`else
  // S0 wins on overlap; slave 1 is the default slave for unmapped addresses
  assign sel_s0 = m_req & hit_s0;
  assign sel_s1 = m_req & ~hit_s0;
`endif

  // Request routing, response steering and next-state decode
  always_comb begin
    state_d  = state_q;
    m_ack    = 1'b0;
    m_resp   = 1'b0;
    m_rdata  = '0;
    s0_req   = 1'b0;
    s0_we    = 1'b0;
    s0_addr  = '0;
    s0_be    = '0;
    s0_wdata = '0;
    s1_req   = 1'b0;
    s1_we    = 1'b0;
    s1_addr  = '0;
    s1_be    = '0;
    s1_wdata = '0;
    case (state_q)
      StIdle: begin
        if (sel_s0) begin
          s0_req   = 1'b1;
          s0_we    = m_we;
          s0_addr  = m_addr;
          s0_be    = m_be;
          s0_wdata = m_wdata;
          m_ack    = s0_ack;
        end else if (sel_s1) begin
          s1_req   = 1'b1;
          s1_we    = m_we;
          s1_addr  = m_addr;
          s1_be    = m_be;
          s1_wdata = m_wdata;
          m_ack    = s1_ack;
`ifdef MEM_DEC_1M2S_ERR_RESP_EN
        end else if (unmapped) begin
          m_ack = 1'b1;
`endif
        end
        // Only an accepted read opens a response phase
        if (m_req && !m_we && m_ack) begin
`ifdef MEM_DEC_1M2S_ERR_RESP_EN
          state_d = sel_s0 ? StRdS0 : (sel_s1 ? StRdS1 : StRdErr);
`else
          state_d = sel_s0 ? StRdS0 : StRdS1;
`endif
        end
      end
      StRdS0: begin
        m_resp  = s0_resp;
        m_rdata = s0_resp ? s0_rdata : '0;
        if (s0_resp) state_d = StIdle;
      end
      StRdS1: begin
        m_resp  = s1_resp;
        m_rdata = s1_resp ? s1_rdata : '0;
        if (s1_resp) state_d = StIdle;
      end
`ifdef MEM_DEC_1M2S_ERR_RESP_EN
      StRdErr: begin
        m_resp  = 1'b1;
        m_rdata = ERR_RDATA;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops any pending read response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mem_dec_1m2s.sv
// Directed bench for mem_dec_1m2s; expected values are hand-computed constants.
module tb_mem_dec_1m2s;
  import sigma_tile_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m_req, m_we, m_ack, m_resp;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        s0_req, s0_we, s0_ack, s0_resp;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic [3:0]  s0_be;
  logic        s1_req, s1_we, s1_ack, s1_resp;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s1_be;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  mem_dec_1m2s dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_be     (m_be),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_resp   (m_resp),
    .m_rdata  (m_rdata),
    .s0_req   (s0_req),
    .s0_we    (s0_we),
    .s0_addr  (s0_addr),
    .s0_be    (s0_be),
    .s0_wdata (s0_wdata),
    .s0_ack   (s0_ack),
    .s0_resp  (s0_resp),
    .s0_rdata (s0_rdata),
    .s1_req   (s1_req),
    .s1_we    (s1_we),
    .s1_addr  (s1_addr),
    .s1_be    (s1_be),
    .s1_wdata (s1_wdata),
    .s1_ack   (s1_ack),
    .s1_resp  (s1_resp),
    .s1_rdata (s1_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_st(input string tag, input dec_state_t exp);
    check(tag, 32'(dut.state_q), 32'(exp));
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_be     = '0;
    m_wdata  = '0;
    s0_ack   = 1'b0;
    s0_resp  = 1'b0;
    s0_rdata = '0;
    s1_ack   = 1'b0;
    s1_resp  = 1'b0;
    s1_rdata = '0;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    #12;
    // Reset state
    check("rst_s0_req", 32'(s0_req), 32'd0);
    check("rst_s1_req", 32'(s1_req), 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_resp", 32'(m_resp), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check_st("rst_state", StIdle);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Write to S0: fields forwarded unchanged, ack same cycle, stays idle
    next_cycle();
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0010; m_wdata = 32'h1234_5678;
    m_be = 4'hF; s0_ack = 1'b1;
    @(negedge clk_i);
    check("wr_s0_req", 32'(s0_req), 32'd1);
    check("wr_s0_we", 32'(s0_we), 32'd1);
    check("wr_s0_addr", s0_addr, 32'h0000_0010);
    check("wr_s0_be", 32'(s0_be), 32'hF);
    check("wr_s0_wdata", s0_wdata, 32'h1234_5678);
    check("wr_m_ack", 32'(m_ack), 32'd1);
    check("wr_s1_req", 32'(s1_req), 32'd0);
    check("wr_s1_wdata", s1_wdata, 32'd0);
    next_cycle();
    clear_inputs();
    check_st("wr_state", StIdle);

    // Read from S1 with response three cycles later, request held throughout
    next_cycle();
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8000_0004; m_be = 4'hF; s1_ack = 1'b1;
    @(negedge clk_i);
    check("rd1_c0_ack", 32'(m_ack), 32'd1);
    check("rd1_c0_s1_req", 32'(s1_req), 32'd1);
    check("rd1_c0_s1_addr", s1_addr, 32'h8000_0004);
    check("rd1_c0_s0_req", 32'(s0_req), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      if (c == 2) s1_rdata = 32'hCAFE_F00D;
      @(negedge clk_i);
      check("rd1_wait_state", 32'(dut.state_q), 32'(StRdS1));
      check("rd1_wait_ack", 32'(m_ack), 32'd0);
      check("rd1_wait_s1_req", 32'(s1_req), 32'd0);
      check("rd1_wait_resp", 32'(m_resp), 32'd0);
      check("rd1_wait_rdata", m_rdata, 32'd0);
    end
    next_cycle();
    s1_resp = 1'b1; s1_rdata = 32'hCAFE_F00D;
    @(negedge clk_i);
    check("rd1_c3_resp", 32'(m_resp), 32'd1);
    check("rd1_c3_rdata", m_rdata, 32'hCAFE_F00D);
    check("rd1_c3_ack", 32'(m_ack), 32'd0);
    next_cycle();
    s1_resp = 1'b0; s1_rdata = '0; m_we = 1'b1;
    @(negedge clk_i);
    check("rd1_c4_ack", 32'(m_ack), 32'd1);
    check("rd1_c4_resp", 32'(m_resp), 32'd0);
    check_st("rd1_c4_state", StIdle);
    next_cycle();
    clear_inputs();

    // Stray S1 response in idle, then while an S0 read is pending
    s1_resp = 1'b1; s1_rdata = 32'h1111_1111;
    @(negedge clk_i);
    check("stray_idle_resp", 32'(m_resp), 32'd0);
    check("stray_idle_rdata", m_rdata, 32'd0);
    next_cycle();
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0020; s0_ack = 1'b1;
    @(negedge clk_i);
    check("rd0_ack", 32'(m_ack), 32'd1);
    check("rd0_s0_req", 32'(s0_req), 32'd1);
    check("rd0_s1_req", 32'(s1_req), 32'd0);
    check("rd0_resp_c0", 32'(m_resp), 32'd0);
    next_cycle();
    m_req = 1'b0; s0_ack = 1'b0;
    @(negedge clk_i);
    check("rd0_pend_state", 32'(dut.state_q), 32'(StRdS0));
    check("rd0_pend_resp", 32'(m_resp), 32'd0);
    check("rd0_pend_rdata", m_rdata, 32'd0);
    next_cycle();
    s0_resp = 1'b1; s0_rdata = 32'hA5A5_0001;
    @(negedge clk_i);
    check("rd0_resp", 32'(m_resp), 32'd1);
    check("rd0_rdata", m_rdata, 32'hA5A5_0001);
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
    check_st("rd0_done_state", StIdle);

    // S0 withholds ack for five cycles
    next_cycle();
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0030; s0_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk_i);
      check("stall_ack", 32'(m_ack), 32'd0);
      check("stall_s0_req", 32'(s0_req), 32'd1);
      check_st("stall_state", StIdle);
    end
    next_cycle();
    s0_ack = 1'b1;
    @(negedge clk_i);
    check("stall_ack_cycle", 32'(m_ack), 32'd1);
    check_st("stall_ack_state", StIdle);
    next_cycle();
    m_req = 1'b0; s0_ack = 1'b0;
    @(negedge clk_i);
    check("stall_rd_state", 32'(dut.state_q), 32'(StRdS0));
    next_cycle();
    s0_resp = 1'b1; s0_rdata = 32'h0000_0005;
    @(negedge clk_i);
    check("stall_rdata", m_rdata, 32'h0000_0005);
    next_cycle();
    clear_inputs();

    // Asynchronous reset in the middle of an S1 read
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8000_0100; s1_ack = 1'b1;
    next_cycle();
    m_req = 1'b0; s1_ack = 1'b0;
    @(negedge clk_i);
    check("arst_pre_state", 32'(dut.state_q), 32'(StRdS1));
    #2;
    rst_ni = 1'b0;
    #1;
    check_st("arst_state", StIdle);
    #1;
    rst_ni = 1'b1;
    next_cycle();
    s1_resp = 1'b1; s1_rdata = 32'h0000_0077;
    @(negedge clk_i);
    check("arst_late_resp", 32'(m_resp), 32'd0);
    check("arst_late_rdata", m_rdata, 32'd0);
    next_cycle();
    clear_inputs();
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0040; m_wdata = 32'h0BAD_F00D;
    m_be = 4'h3; s0_ack = 1'b1;
    @(negedge clk_i);
    check("arst_wr_ack", 32'(m_ack), 32'd1);
    check("arst_wr_s0_wdata", s0_wdata, 32'h0BAD_F00D);
    check("arst_wr_s0_be", 32'(s0_be), 32'h3);
    next_cycle();
    clear_inputs();

    // Unmapped access to 0x4000_0000
`ifdef MEM_DEC_1M2S_ERR_RESP_EN
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0000; s0_ack = 1'b1;
    @(negedge clk_i);
    check("err_rd_ack", 32'(m_ack), 32'd1);
    check("err_rd_s0_req", 32'(s0_req), 32'd0);
    check("err_rd_s1_req", 32'(s1_req), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
    check("err_rd_resp", 32'(m_resp), 32'd1);
    check("err_rd_rdata", m_rdata, 32'hDEAD_BEEF);
    check("err_rd_busy_ack", 32'(m_ack), 32'd0);
    next_cycle();
    @(negedge clk_i);
    check("err_rd_resp_end", 32'(m_resp), 32'd0);
    check_st("err_rd_state", StIdle);
    next_cycle();
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h4000_0000; m_wdata = 32'h1;
    @(negedge clk_i);
    check("err_wr_ack", 32'(m_ack), 32'd1);
    check("err_wr_s1_req", 32'(s1_req), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
    check_st("err_wr_state", StIdle);
`else
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0000; s1_ack = 1'b1;
    @(negedge clk_i);
    check("dflt_rd_s1_req", 32'(s1_req), 32'd1);
    check("dflt_rd_s1_addr", s1_addr, 32'h4000_0000);
    check("dflt_rd_s0_req", 32'(s0_req), 32'd0);
    check("dflt_rd_ack", 32'(m_ack), 32'd1);
    next_cycle();
    clear_inputs();
    s1_resp = 1'b1; s1_rdata = 32'h0000_0099;
    @(negedge clk_i);
    check("dflt_rd_resp", 32'(m_resp), 32'd1);
    check("dflt_rd_rdata", m_rdata, 32'h0000_0099);
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
    check_st("dflt_rd_state", StIdle);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
